// File: rtl/blk_959f9c.sv
// blk_959f9c: output-side SSN bus pipe with reset synchroniser, flush FSM and optional negedge lockup stage.
// Revision 1.0 - initial release.
`default_nettype none

module blk_959f9c #(
  parameter int BUS_WIDTH  = 20,
  parameter int PIPE_DEPTH = 2,
  parameter int NEG_RETIME = 1
) (
  input  logic                 bus_clock,
  input  logic                 ijtag_reset,
  input  logic [BUS_WIDTH-1:0] bus_data_in,
  output logic [BUS_WIDTH-1:0] bus_data_out,
  output logic                 bus_pipe_ready
);

  localparam int                CNT_W    = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     flush_cnt;
  logic [CNT_W-1:0]     flush_cnt_nxt;
  logic [1:0]           sync_q;
  logic                 bus_sync_reset_pulse;
  logic                 run_state;
  logic                 out_en;
  logic [BUS_WIDTH-1:0] pipe_q [PIPE_DEPTH];
  logic [BUS_WIDTH-1:0] last_stage;

  always_ff @(posedge bus_clock or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign bus_sync_reset_pulse = ~sync_q[1];

  always_ff @(posedge bus_clock or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state          <= ST_RESET;
      flush_cnt      <= '0;
      bus_pipe_ready <= 1'b0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      bus_pipe_ready <= run_state;
    end
  end

  // Leave RESET on the same edge that the synchroniser output deasserts.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_RESET: begin
        flush_cnt_nxt = '0;
        if (sync_q[0]) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt != CNT_MAX) begin
          flush_cnt_nxt = flush_cnt + 1'b1;
        end
        if (flush_cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  assign run_state = (state_nxt == ST_RUN);

  always_ff @(posedge bus_clock) begin
    if (bus_sync_reset_pulse) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= bus_data_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  generate
    if (NEG_RETIME != 0) begin : g_neg_retime
      logic [BUS_WIDTH-1:0] neg_q;

      always_ff @(negedge bus_clock) begin
        if (bus_sync_reset_pulse) begin
          neg_q <= '0;
        end else begin
          neg_q <= pipe_q[PIPE_DEPTH-1];
        end
      end

      always_ff @(negedge bus_clock or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
          out_en <= 1'b0;
        end else begin
          out_en <= run_state;
        end
      end

      assign last_stage = neg_q;
    end else begin : g_pos_out
      always_ff @(posedge bus_clock or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
          out_en <= 1'b0;
        end else begin
          out_en <= run_state;
        end
      end

      assign last_stage = pipe_q[PIPE_DEPTH-1];
    end
  endgenerate

  assign bus_data_out = out_en ? last_stage : '0;

endmodule

`default_nettype wire
